// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge: default IDs, AXI encodings,
// read/write FSM state codes and the byte-strobe helper.
package cpu_axi_bridge_pkg;

    localparam logic [3:0] INST_ID_DEF = 4'd0;
    localparam logic [3:0] DATA_ID_DEF = 4'd1;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } w_state_t;

    typedef struct packed {
        r_state_t r_state;
        w_state_t w_state;
        logic     r_src_data;
        logic     aw_pend;
        logic     w_pend;
    } bridge_dbg_t;

    // Byte lanes touched by a store; the core has already placed the data in those lanes.
    function automatic logic [3:0] wstrb_from_size(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 4'b0001 << addr_lo;
            SIZE_H:  return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's sram-like instruction/data ports onto one AXI3 master port,
// with one read FSM (shared by inst and data) and one write FSM (data stores only).
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output bridge_dbg_t dbg
);

    // Handshakes: a transfer happens on a rising edge where valid (or req) and ready (or
    // addr_ok) are both high; valid and its payload hold steady until that edge.
    r_state_t    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [1:0]  r_size_q, r_size_d;
    logic        r_src_q, r_src_d;

    w_state_t    w_state_q, w_state_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [1:0]  w_size_q, w_size_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;

    logic r_idle, w_idle, data_rd_pend;
    logic data_rd_grant, data_wr_grant, inst_grant;
    logic aw_left, w_left;

    assign r_idle       = (r_state_q == R_IDLE);
    assign w_idle       = (w_state_q == W_IDLE);
    assign data_rd_pend = !r_idle && r_src_q;

    // Data reads wait for the write FSM to drain so a load never overtakes an older store.
    assign data_rd_grant = data_req && !data_wr && r_idle && w_idle;
    assign data_wr_grant = data_req && data_wr && w_idle && !data_rd_pend;
    assign inst_grant    = inst_req && r_idle && !data_rd_grant;

    assign aw_left = aw_pend_q && !awready;
    assign w_left  = w_pend_q && !wready;

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        r_src_d   = r_src_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_grant) begin
                    r_addr_d  = data_addr;
                    r_size_d  = data_size;
                    r_src_d   = 1'b1;
                    r_state_d = R_AR;
                end else if (inst_grant) begin
                    r_addr_d  = inst_addr;
                    r_size_d  = inst_size;
                    r_src_d   = 1'b0;
                    r_state_d = R_AR;
                end
            end
            R_AR:    if (arready) r_state_d = R_R;
            R_R:     if (rvalid) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_grant) begin
                    w_addr_d  = data_addr;
                    w_size_d  = data_size;
                    w_data_d  = data_wdata;
                    w_strb_d  = wstrb_from_size(data_size, data_addr[1:0]);
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    w_state_d = W_AW;
                end
            end
            // AW and W retire independently; the response phase starts once both have gone.
            W_AW: begin
                aw_pend_d = aw_left;
                w_pend_d  = w_left;
                if (!aw_left && !w_left) w_state_d = W_B;
            end
            W_B:     if (bvalid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_size_q  <= '0;
            r_src_q   <= 1'b0;
            w_state_q <= W_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            r_src_q   <= r_src_d;
            w_state_q <= w_state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

    assign inst_addr_ok = inst_grant;
    assign data_addr_ok = data_rd_grant || data_wr_grant;

    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_R);
    assign awvalid = (w_state_q == W_AW) && aw_pend_q;
    assign wvalid  = (w_state_q == W_AW) && w_pend_q;
    assign bready  = (w_state_q == W_B);

    assign inst_data_ok = rready && rvalid && !r_src_q;
    assign data_data_ok = (rready && rvalid && r_src_q) || (bready && bvalid);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = r_src_q ? DATA_ID : INST_ID;
    assign araddr  = r_addr_q;
    assign arsize  = {1'b0, r_size_q};
    assign arlen   = 4'd0;
    assign arburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = DATA_ID;
    assign awaddr  = w_addr_q;
    assign awsize  = {1'b0, w_size_q};
    assign awlen   = 4'd0;
    assign awburst = BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = DATA_ID;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;

    assign dbg = '{r_state: r_state_q, w_state: w_state_q, r_src_data: r_src_q,
                   aw_pend: aw_pend_q, w_pend: w_pend_q};

    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Random and directed traffic through the bridge against a word-addressed memory model
// and a small AXI slave; expected responses are queued at issue and popped by monitors.
module tb_cpu_axi_bridge;
    import cpu_axi_bridge_pkg::*;

    logic        clk, resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    bridge_dbg_t dbg;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .dbg(dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passes = 0;

    logic [31:0] inst_exp_q[$];
    logic [32:0] data_exp_q[$];   // {is_store, load word}
    logic [38:0] ar_exp_q[$];     // {id, size, addr}
    logic [70:0] aw_exp_q[$];     // {addr, size, wdata, strb}

    logic [31:0] ref_mem[logic [29:0]];
    logic [31:0] slave_mem[logic [29:0]];

    int ar_stall = -1, r_delay = -1, aw_delay = -1, w_delay = -1, b_delay = -1;

    task automatic check_val(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int pick(input int fixed, input int max);
        return (fixed >= 0) ? fixed : int'($urandom_range(0, max));
    endfunction

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa[15:0] ^ 16'h5A5A, ~wa[15:0]};
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic logic [31:0] slave_get(input logic [31:0] a);
        return slave_mem.exists(a[31:2]) ? slave_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
        return res;
    endfunction

    // Strobe from access size: a byte covers one lane, a half covers an aligned pair.
    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return 4'(3 << (lane / 2 * 2));
        return 4'hF;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a[31:2]]   = v;
        slave_mem[a[31:2]] = v;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue_inst(input logic [31:0] addr, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        inst_req  = 1'b1;
        inst_addr = addr;
        inst_size = 2'd2;
        while (!ok && waited < 200) begin
            @(negedge clk);
            waited++;
            if (inst_addr_ok) ok = 1;
        end
        if (ok) begin
            check_val("inst_one_outstanding", inst_exp_q.size(), 0);
            inst_exp_q.push_back(ref_get(addr));
            ar_exp_q.push_back({4'd0, 3'd2, addr});
        end else begin
            check_val("inst_accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1 inst_req = 1'b0;
    endtask

    task automatic issue_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wd);
        bit ok;
        int n;
        logic [3:0] strb;
        ok = 0;
        n = 0;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wd;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (data_addr_ok) ok = 1;
        end
        if (ok) begin
            check_val("data_one_outstanding", data_exp_q.size(), 0);
            if (wr) begin
                strb = model_strb(size, addr);
                ref_mem[addr[31:2]] = merge(ref_get(addr), wd, strb);
                aw_exp_q.push_back({addr, 1'b0, size, wd, strb});
                data_exp_q.push_back({1'b1, 32'h0});
            end else begin
                ar_exp_q.push_back({4'd1, 1'b0, size, addr});
                data_exp_q.push_back({1'b0, ref_get(addr)});
            end
        end else begin
            check_val("data_accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1 data_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 400 && (inst_exp_q.size() != 0 || data_exp_q.size() != 0 ||
               arvalid || rready || awvalid || wvalid || bready)) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", inst_exp_q.size() + data_exp_q.size() + ar_exp_q.size() + aw_exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- response monitor ----------------
    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (inst_data_ok) begin
                    if (inst_exp_q.size() == 0) check_val("inst_spurious_data_ok", 1, 0);
                    else check_val("inst_rdata", inst_rdata, inst_exp_q.pop_front());
                end
                if (data_data_ok) begin
                    if (data_exp_q.size() == 0) begin
                        check_val("data_spurious_data_ok", 1, 0);
                    end else begin
                        e = data_exp_q.pop_front();
                        if (!e[32]) check_val("data_rdata", data_rdata, e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- AXI read slave ----------------
    initial begin : read_slave
        logic [31:0] ra;
        logic [3:0]  rid_l;
        int n, k;
        bit abandon;
        arready = 1'b0;
        rvalid  = 1'b0;
        rid     = 4'd0;
        rdata   = 32'd0;
        rresp   = 2'd0;
        rlast   = 1'b1;
        forever begin
            @(negedge clk);
            if (!resetn || !arvalid) continue;
            ra    = araddr;
            rid_l = arid;
            if (ar_exp_q.size() == 0) check_val("ar_unexpected", 1, 0);
            else check_val("ar_req", {arid, arsize, araddr}, ar_exp_q.pop_front());
            check_val("ar_ties", {arlen, arburst, arlock, arcache, arprot},
                      {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
            n = pick(ar_stall, 2);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                check_val("ar_stable", {arvalid, araddr}, {1'b1, ra});
            end
            @(posedge clk);
            #1 arready = 1'b1;
            @(posedge clk);
            #1 arready = 1'b0;
            abandon = 0;
            n = pick(r_delay, 3);
            for (int i = 0; i < n; i++) begin
                @(posedge clk);
                #1;
                if (!resetn) begin
                    abandon = 1;
                    break;
                end
            end
            if (abandon) continue;
            rvalid = 1'b1;
            rid    = rid_l;
            rdata  = slave_get(ra);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!rready && k < 100);
            if (!rready) check_val("rready_timeout", 0, 1);
            @(posedge clk);
            #1 rvalid = 1'b0;
        end
    end

    // ---------------- AXI write slave ----------------
    initial begin : write_slave
        logic [31:0] wa, wd;
        logic [3:0]  ws;
        int da, dw, cyc, k;
        bit aw_done, w_done;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = 4'd1;
        bresp   = 2'd0;
        forever begin
            @(negedge clk);
            if (!resetn || !(awvalid || wvalid)) continue;
            wa = awaddr;
            wd = wdata;
            ws = wstrb;
            check_val("aw_w_start", {awvalid, wvalid, wlast}, 3'b111);
            if (aw_exp_q.size() == 0) check_val("aw_unexpected", 1, 0);
            else check_val("aw_req", {awaddr, awsize, wdata, wstrb}, aw_exp_q.pop_front());
            check_val("aw_ids_ties", {awid, wid, awlen, awburst, awlock, awcache, awprot},
                      {4'd1, 4'd1, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
            da = pick(aw_delay, 3);
            dw = pick(w_delay, 3);
            aw_done = 0;
            w_done  = 0;
            cyc     = 0;
            while (!(aw_done && w_done) && cyc < 20) begin
                @(posedge clk);
                #1;
                awready = !aw_done && (cyc == da);
                wready  = !w_done && (cyc == dw);
                @(negedge clk);
                check_val("aw_w_valid", {awvalid, wvalid, bready}, {!aw_done, !w_done, 1'b0});
                if (awready) aw_done = 1;
                if (wready) w_done = 1;
                cyc++;
            end
            if (!(aw_done && w_done)) check_val("aw_w_timeout", 0, 1);
            @(posedge clk);
            #1;
            awready = 1'b0;
            wready  = 1'b0;
            for (int i = 0; i < pick(b_delay, 3); i++) begin
                @(posedge clk);
                #1;
            end
            slave_mem[wa[31:2]] = merge(slave_get(wa), wd, ws);
            bvalid = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bready && k < 100);
            if (!bready) check_val("bready_timeout", 0, 1);
            @(posedge clk);
            #1 bvalid = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int waited;
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_size  = 2'd0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;

        @(negedge clk);
        check_val("reset_outputs",
                  {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok,
                   inst_data_ok, data_data_ok}, 9'd0);
        check_val("reset_state", {dbg.r_state, dbg.w_state}, {R_IDLE, W_IDLE});
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Boot fetch with a fixed two-cycle read response.
        preload(32'hBFC00000, 32'h3C080001);
        ar_stall = 0;
        r_delay  = 2;
        issue_inst(32'hBFC00000, waited);
        wait_idle();

        // Simultaneous inst and data reads: data wins, inst retries.
        ar_stall = -1;
        r_delay  = -1;
        fork
            issue_inst(32'hBFC00040, waited);
            issue_data(1'b0, 2'd2, 32'h80000010, 32'd0);
            begin
                @(negedge clk);
                check_val("arb_data_wins", {data_addr_ok, inst_addr_ok}, 2'b10);
            end
        join
        wait_idle();

        // Byte store into the top lane, W lagging AW by three cycles, then read back.
        aw_delay = 0;
        w_delay  = 3;
        b_delay  = 1;
        issue_data(1'b1, 2'd0, 32'h80000003, 32'hAB000000);
        issue_data(1'b0, 2'd2, 32'h80000000, 32'd0);
        wait_idle();

        // Slow write response: a following load must not be accepted before it.
        aw_delay = -1;
        w_delay  = -1;
        b_delay  = 12;
        issue_data(1'b1, 2'd2, 32'h80000020, 32'hDEADBEEF);
        issue_data(1'b0, 2'd2, 32'h80000020, 32'd0);
        wait_idle();
        b_delay = -1;

        // Read address stalled for five cycles with a second fetch queued behind it.
        ar_stall = 5;
        issue_inst(32'hBFC00080, waited);
        issue_inst(32'hBFC00084, waited);
        wait_idle();
        ar_stall = -1;

        // Concurrent random traffic on both ports.
        fork
            begin : inst_rand
                for (int i = 0; i < 40; i++) begin
                    int w;
                    issue_inst(32'hBFC00000 + 32'(4 * $urandom_range(0, 63)), w);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin : data_rand
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] a;
                    logic [1:0]  sz;
                    sz = 2'($urandom_range(0, 2));
                    a  = 32'h80000000 + 32'($urandom_range(0, 63));
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'b00;
                    issue_data(1'($urandom_range(0, 1)), sz, a, $urandom);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        join
        wait_idle();

        // Reset while waiting for read data, then a fresh fetch straight after release.
        ar_stall = 0;
        r_delay  = 30;
        issue_inst(32'hBFC00100, waited);
        waited = 0;
        while (!rready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_val("reached_r_phase", rready, 1);
        #2 resetn = 1'b0;
        #1;
        check_val("async_reset_outputs",
                  {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 7'd0);
        inst_exp_q.delete();
        ar_exp_q.delete();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        r_delay = -1;
        issue_inst(32'hBFC00104, waited);
        check_val("post_reset_accept_cycle", waited, 1);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
